// File: rtl/clks_pkg.sv
// Shared types and defaults for the clock-lock reset sequencer.
package clks_pkg;

  // FSM state codes; the encoding is visible on stateOut.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_LOCK = 2'b01,
    SETTLE    = 2'b10,
    RUN       = 2'b11
  } seq_state_e;

  localparam int DEFAULT_SETTLE_CYCLES = 1024;
  localparam int DEFAULT_SYNC_DEPTH    = 3;

endpackage : clks_pkg

// File: rtl/synchronizer_ff.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module synchronizer_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  // Shift the raw input one stage further down the chain every cycle.
  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d};
  end

  // Synchronizer stages, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[DEPTH-1];

endmodule : synchronizer_ff

// File: rtl/lock_rst_sequencer.sv
// Holds the system reset until both MMCMs are locked and have stayed locked
// for SETTLE_CYCLES cycles, then tracks lock losses while running.
module lock_rst_sequencer
  import clks_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int SYNC_DEPTH    = DEFAULT_SYNC_DEPTH,
  parameter int LOSS_CNT_W    = 8
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  mmcm0LockedIn,
  input  logic                  mmcm1LockedIn,
  output logic                  rstSysOut,
  output logic                  readyOut,
  output logic [1:0]            stateOut,
  output logic                  lockLossPulseOut,
  output logic [LOSS_CNT_W-1:0] lockLossCntOut
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic lk0;
  logic lk1;
  logic both_locked;

  seq_state_e state_q, state_d;
  logic [CNT_W-1:0]      settle_cnt_q, settle_cnt_d;
  logic                  rst_sys_q, rst_sys_d;
  logic                  ready_q, ready_d;
  logic                  loss_pulse_q, loss_pulse_d;
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  synchronizer_ff #(
    .DEPTH(SYNC_DEPTH)
  ) u_sync_lock0 (
    .clk(clkIn),
    .rst(rstIn),
    .d  (mmcm0LockedIn),
    .q  (lk0)
  );

  synchronizer_ff #(
    .DEPTH(SYNC_DEPTH)
  ) u_sync_lock1 (
    .clk(clkIn),
    .rst(rstIn),
    .d  (mmcm1LockedIn),
    .q  (lk1)
  );

  assign both_locked = lk0 & lk1;

  // State, settle counter and all registered outputs; reset overrides everything.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      rst_sys_q    <= 1'b1;
      ready_q      <= 1'b0;
      loss_pulse_q <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      rst_sys_q    <= rst_sys_d;
      ready_q      <= ready_d;
      loss_pulse_q <= loss_pulse_d;
      loss_cnt_q   <= loss_cnt_d;
    end
  end

  // Next state and settle count; a lock drop always beats the terminal count.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    unique case (state_q)
      IDLE: begin
        state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        settle_cnt_d = '0;
        if (both_locked) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q != '1) begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
        if (!both_locked) begin
          state_d = WAIT_LOCK;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!both_locked) begin
          state_d = WAIT_LOCK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so they move with the state flop.
  always_comb begin
    rst_sys_d    = (state_d != RUN);
    ready_d      = (state_d == RUN);
    loss_pulse_d = (state_q == RUN) && !both_locked;
    loss_cnt_d   = loss_cnt_q;
    if (loss_pulse_d && (loss_cnt_q != '1)) begin
      loss_cnt_d = loss_cnt_q + 1'b1;
    end
  end

  assign rstSysOut        = rst_sys_q;
  assign readyOut         = ready_q;
  assign stateOut         = state_q;
  assign lockLossPulseOut = loss_pulse_q;
  assign lockLossCntOut   = loss_cnt_q;

endmodule : lock_rst_sequencer

// File: tb/tb_lock_rst_sequencer.sv
// Directed bench for lock_rst_sequencer with short settle time and a 2-bit loss counter.
module tb_lock_rst_sequencer;

  localparam int SETTLE_CYCLES = 16;
  localparam int SYNC_DEPTH    = 3;
  localparam int LOSS_CNT_W    = 2;

  logic                  clkIn;
  logic                  rstIn;
  logic                  mmcm0LockedIn;
  logic                  mmcm1LockedIn;
  logic                  rstSysOut;
  logic                  readyOut;
  logic [1:0]            stateOut;
  logic                  lockLossPulseOut;
  logic [LOSS_CNT_W-1:0] lockLossCntOut;

  int assertCount;
  int failCount;
  int pulseSeen;

  lock_rst_sequencer #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .SYNC_DEPTH   (SYNC_DEPTH),
    .LOSS_CNT_W   (LOSS_CNT_W)
  ) dut (
    .clkIn           (clkIn),
    .rstIn           (rstIn),
    .mmcm0LockedIn   (mmcm0LockedIn),
    .mmcm1LockedIn   (mmcm1LockedIn),
    .rstSysOut       (rstSysOut),
    .readyOut        (readyOut),
    .stateOut        (stateOut),
    .lockLossPulseOut(lockLossPulseOut),
    .lockLossCntOut  (lockLossCntOut)
  );

  // 100 MHz free-running clock.
  initial begin
    clkIn = 1'b0;
    forever #5 clkIn = ~clkIn;
  end

  task automatic applyStimulus(input logic rst, input logic lock0, input logic lock1);
    rstIn         = rst;
    mmcm0LockedIn = lock0;
    mmcm1LockedIn = lock1;
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic stepCycles(input int n);
    repeat (n) @(posedge clkIn);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Directed sequence: reset, release, RUN loss, reset in RUN, settle drop, saturation, collision.
  initial begin
    assertCount = 0;
    failCount   = 0;
    pulseSeen   = 0;

    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycles(2);
    checkOutput("rst_state", 8'(stateOut), 8'd0);
    checkOutput("rst_rstSys", 8'(rstSysOut), 8'd1);
    checkOutput("rst_ready", 8'(readyOut), 8'd0);
    checkOutput("rst_pulse", 8'(lockLossPulseOut), 8'd0);
    checkOutput("rst_cnt", 8'(lockLossCntOut), 8'd0);

    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycles(1);
    checkOutput("idle_to_wait", 8'(stateOut), 8'd1);

    $display("[TB] release timing");
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepCycles(3);
    checkOutput("rel_still_wait", 8'(stateOut), 8'd1);
    stepCycles(1);
    checkOutput("rel_settle", 8'(stateOut), 8'd2);
    stepCycles(15);
    checkOutput("rel_t19_state", 8'(stateOut), 8'd2);
    checkOutput("rel_t19_rstSys", 8'(rstSysOut), 8'd1);
    stepCycles(1);
    checkOutput("rel_t20_state", 8'(stateOut), 8'd3);
    checkOutput("rel_t20_rstSys", 8'(rstSysOut), 8'd0);
    checkOutput("rel_t20_ready", 8'(readyOut), 8'd1);

    $display("[TB] lock drop in RUN");
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepCycles(2);
    checkOutput("run_drop_t3_rstSys", 8'(rstSysOut), 8'd0);
    stepCycles(1);
    checkOutput("run_drop_t4_rstSys", 8'(rstSysOut), 8'd1);
    checkOutput("run_drop_t4_pulse", 8'(lockLossPulseOut), 8'd1);
    checkOutput("run_drop_t4_cnt", 8'(lockLossCntOut), 8'd1);
    checkOutput("run_drop_t4_state", 8'(stateOut), 8'd1);
    stepCycles(1);
    checkOutput("run_drop_t5_pulse", 8'(lockLossPulseOut), 8'd0);
    stepCycles(15);
    checkOutput("run_drop_t20_state", 8'(stateOut), 8'd2);
    stepCycles(1);
    checkOutput("run_drop_t21_state", 8'(stateOut), 8'd3);
    checkOutput("run_drop_t21_ready", 8'(readyOut), 8'd1);

    $display("[TB] reset while in RUN");
    applyStimulus(1'b1, 1'b1, 1'b1);
    stepCycles(1);
    checkOutput("rstrun_state", 8'(stateOut), 8'd0);
    checkOutput("rstrun_rstSys", 8'(rstSysOut), 8'd1);
    checkOutput("rstrun_ready", 8'(readyOut), 8'd0);
    checkOutput("rstrun_cnt", 8'(lockLossCntOut), 8'd0);

    $display("[TB] lock drop during settle");
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepCycles(4);
    checkOutput("sdrop_settle", 8'(stateOut), 8'd2);
    stepCycles(8);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycles(2);
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepCycles(1);
    checkOutput("sdrop_still_settle", 8'(stateOut), 8'd2);
    stepCycles(1);
    checkOutput("sdrop_wait", 8'(stateOut), 8'd1);
    checkOutput("sdrop_pulse", 8'(lockLossPulseOut), 8'd0);
    checkOutput("sdrop_cnt", 8'(lockLossCntOut), 8'd0);
    stepCycles(17);
    checkOutput("sdrop_t19_state", 8'(stateOut), 8'd2);
    checkOutput("sdrop_t19_rstSys", 8'(rstSysOut), 8'd1);
    stepCycles(1);
    checkOutput("sdrop_t20_state", 8'(stateOut), 8'd3);
    checkOutput("sdrop_t20_rstSys", 8'(rstSysOut), 8'd0);
    checkOutput("sdrop_t20_cnt", 8'(lockLossCntOut), 8'd0);

    $display("[TB] loss counter saturation");
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      stepCycles(1);
      pulseSeen += int'(lockLossPulseOut);
      applyStimulus(1'b0, 1'b1, 1'b1);
      for (int c = 1; c < 21; c++) begin
        stepCycles(1);
        pulseSeen += int'(lockLossPulseOut);
      end
      checkOutput("sat_cnt", 8'(lockLossCntOut), (k > 3) ? 8'd3 : 8'(k));
      checkOutput("sat_state", 8'(stateOut), 8'd3);
    end
    checkOutput("sat_pulses", 8'(pulseSeen), 8'd5);

    $display("[TB] drop coincident with settle terminal count");
    applyStimulus(1'b1, 1'b1, 1'b1);
    stepCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepCycles(4);
    checkOutput("coll_settle", 8'(stateOut), 8'd2);
    stepCycles(12);
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepCycles(2);
    checkOutput("coll_pre_term", 8'(stateOut), 8'd2);
    stepCycles(1);
    checkOutput("coll_state", 8'(stateOut), 8'd1);
    checkOutput("coll_ready", 8'(readyOut), 8'd0);
    checkOutput("coll_rstSys", 8'(rstSysOut), 8'd1);
    checkOutput("coll_pulse", 8'(lockLossPulseOut), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_lock_rst_sequencer

// File: doc/lock_rst_sequencer.md
LOCK_RST_SEQUENCER -- requirements
Module: lock_rst_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1024: number of cycles both locks must stay high before release; legal range >= 1.
REQ-002 SHALL have parameter SYNC_DEPTH, default 3: flop stages per lock synchronizer; legal range >= 2.
REQ-003 SHALL have parameter LOSS_CNT_W, default 8: width of the lock-loss counter.
REQ-004 clkIn  input  1  100 MHz board clock after BUFG; the only clock in this block.
REQ-005 rstIn  input  1  reset, synchronous, active-high.
REQ-006 mmcm0LockedIn  input  1  MMCM0 locked indication; asynchronous to clkIn.
REQ-007 mmcm1LockedIn  input  1  MMCM1 locked indication; asynchronous to clkIn.
REQ-008 rstSysOut  output  1  active-high reset released to the downstream clock-domain reset synchronizers.
REQ-009 readyOut  output  1  high while both clocks are locked and settled.
REQ-010 stateOut  output  2  current FSM state code.
REQ-011 lockLossPulseOut  output  1  one-cycle strobe on each lock loss that occurs while in RUN.
REQ-012 lockLossCntOut  output  LOSS_CNT_W  count of lock losses in RUN; saturates.

Function
REQ-013 Each locked input SHALL pass through its own SYNC_DEPTH-stage synchronizer; the FSM SHALL see only the synchronized values, called lk0 and lk1 below.
REQ-014 The FSM SHALL have four states, encoded IDLE=00, WAIT_LOCK=01, SETTLE=10, RUN=11.
REQ-015 IDLE SHALL go to WAIT_LOCK on the next cycle unconditionally.
REQ-016 WAIT_LOCK SHALL go to SETTLE when lk0 and lk1 are both 1, clearing the settle counter to 0.
REQ-017 In SETTLE, the settle counter SHALL increment every cycle; the state SHALL go to RUN on the cycle the counter equals SETTLE_CYCLES-1 with lk0 and lk1 both 1, so SETTLE lasts exactly SETTLE_CYCLES cycles.
REQ-018 In SETTLE, if lk0 or lk1 is 0, the state SHALL go to WAIT_LOCK; this SHALL NOT count as a lock loss.
REQ-019 Lock drop on the same cycle as the settle terminal count SHALL win: next state is WAIT_LOCK.
REQ-020 In RUN, if lk0 or lk1 is 0, the state SHALL go to WAIT_LOCK, assert lockLossPulseOut for exactly one cycle, and increment lockLossCntOut, holding at all-ones.
REQ-021 All outputs SHALL be registered and derived from the next state, so they change on the same edge as the state register.
REQ-022 rstSysOut SHALL be 0 only in RUN, and readyOut SHALL be 1 only in RUN.
REQ-023 Latency from a raw rise of both locked inputs to the rstSysOut fall SHALL be SYNC_DEPTH+1+SETTLE_CYCLES cycles when starting in WAIT_LOCK.
REQ-024 Latency from a raw locked fall in RUN to the rstSysOut rise SHALL be SYNC_DEPTH+1 cycles.
REQ-025 The settle counter width SHALL be $clog2(SETTLE_CYCLES+1) bits, and the counter SHALL NOT wrap.

Reset
REQ-026 rstIn SHALL override every other condition, including any in-flight settle or lock-loss event.
REQ-027 On the clock edge where rstIn=1, the block SHALL set: state=IDLE, rstSysOut=1, readyOut=0, lockLossPulseOut=0, lockLossCntOut=0, settle counter=0, all synchronizer flops=0.
REQ-028 rstIn asserted while in RUN SHALL return rstSysOut to 1 on the next edge.

Structure
REQ-029 Package clks_pkg SHALL hold the FSM state enum typedef (2-bit) and the default SETTLE_CYCLES and SYNC_DEPTH constants.
REQ-030 The block SHALL instantiate the existing synchronizer_ff sub-module twice, with DEPTH=SYNC_DEPTH, and SHALL contain no other sub-modules.

Verification
REQ-031 Bench parameters SHALL be SETTLE_CYCLES=16, SYNC_DEPTH=3, LOSS_CNT_W=2.
REQ-032 Release timing: after reset, raise both locks at cycle t -> rstSysOut falls and readyOut rises exactly at t+20 (3+1+16); stateOut=11.
REQ-033 Drop during settle: drop mmcm1LockedIn 8 cycles into SETTLE for 2 cycles -> return to WAIT_LOCK, settle restarts, lockLossCntOut=0, no pulse, release 20 cycles after the relock.
REQ-034 Drop in RUN: pulse mmcm0LockedIn low for 1 cycle in RUN -> rstSysOut=1 at +4, one lockLossPulseOut, lockLossCntOut=1, RUN re-entered after settle.
REQ-035 Saturation: 5 lock losses in RUN -> lockLossCntOut=3, and 5 single-cycle pulses observed.
REQ-036 Reset and collision: rstIn in RUN -> next edge IDLE, rstSysOut=1, lockLossCntOut=0; lock drop coincident with settle terminal count -> WAIT_LOCK, readyOut stays 0.
